avalon_pwm_multi: RTL and testbench

Multi-channel, parametrised PWM generator with an Avalon-MM slave register interface. This is the next generation of the single-channel PWM wrapper. It adds per-channel period/duty registers with shadow (double-buffered) update at the period boundary, per-channel enables, and sticky period-wrap flags with an interrupt output. It sits on the Qsys fabric as a memory-mapped slave and drives NUM_CH conduit PWM pins.

---
 rtl/avalon_pwm_multi.sv | 156 +++++++++++++++
 tb/tb_avalon_pwm_multi.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pwm_multi.sv
// Multi-channel PWM generator behind an Avalon-MM slave register file.
// Each channel double-buffers period/duty and adopts the shadow values at its period wrap.
module avalon_pwm_multi #(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int          ADDR_W     = 4,
  parameter int unsigned DEF_PERIOD = 500000,
  parameter int unsigned DEF_DUTY   = 250000
) (
  input  logic              csi_clk,
  input  logic              rsi_rst_n,
  input  logic              avs_s0_chip_select,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  input  logic [ADDR_W-1:0] avs_s0_address,
  input  logic [3:0]        avs_s0_byteenable,
  input  logic [31:0]       avs_s0_writedata,
  output logic [31:0]       avs_s0_readdata,
  output logic              ins_irq,
  output logic [NUM_CH-1:0] coe_pwm_out
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DUTY);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic              wr_en;
  logic              rd_en;
  logic              ctrl_hit;
  logic              status_hit;
  logic [NUM_CH-1:0] ch_en_reg;
  logic [NUM_CH-1:0] irq_en_reg;
  logic [NUM_CH-1:0] flag_vec;
  logic [NUM_CH-1:0] pend_vec;
  logic [NUM_CH-1:0] clr_vec;
  logic [31:0]       ctrl_word;
  logic [31:0]       status_word;
  logic [31:0]       rd_word;
  logic [31:0]       readdata_reg;
  logic [CNT_W-1:0]  period_s_arr [NUM_CH];
  logic [CNT_W-1:0]  duty_s_arr   [NUM_CH];

  // Byte-lane write merge; bits at or above CNT_W simply do not exist in the target.
  function automatic logic [CNT_W-1:0] lane_merge(input logic [CNT_W-1:0] old_val,
                                                  input logic [31:0]      wdata,
                                                  input logic [3:0]       lanes);
    logic [CNT_W-1:0] res;
    for (int b = 0; b < CNT_W; b++) begin
      res[b] = lanes[b/8] ? wdata[b] : old_val[b];
    end
    return res;
  endfunction

  assign wr_en      = avs_s0_chip_select & avs_s0_write;
  assign rd_en      = avs_s0_chip_select & avs_s0_read;
  assign ctrl_hit   = wr_en && (avs_s0_address == ADDR_W'(0));
  assign status_hit = wr_en && (avs_s0_address == ADDR_W'(1));
  assign clr_vec    = (status_hit && avs_s0_byteenable[0]) ? avs_s0_writedata[NUM_CH-1:0] : '0;

  always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
    if (!rsi_rst_n) begin
      ch_en_reg  <= '1;
      irq_en_reg <= '0;
    end else if (ctrl_hit) begin
      if (avs_s0_byteenable[0]) ch_en_reg  <= avs_s0_writedata[NUM_CH-1:0];
      if (avs_s0_byteenable[2]) irq_en_reg <= avs_s0_writedata[16 +: NUM_CH];
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] period_s_reg;
    logic [CNT_W-1:0] duty_s_reg;
    logic [CNT_W-1:0] period_a_reg;
    logic [CNT_W-1:0] duty_a_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             per_hit;
    logic             duty_hit;
    logic             period_zero;
    logic             at_end;
    logic             wrap;
    logic             load;
    logic             flag_reg;
    logic             pend_reg;
    logic             pwm_reg;

    assign per_hit     = wr_en && (avs_s0_address == ADDR_W'(2 + 2*gi));
    assign duty_hit    = wr_en && (avs_s0_address == ADDR_W'(3 + 2*gi));
    assign period_zero = (period_a_reg == '0);
    assign at_end      = ~period_zero && (cnt_reg == period_a_reg - ONE);
    assign wrap        = ch_en_reg[gi] & at_end;
    // An idle channel (disabled or zero period) tracks its shadow every cycle.
    assign load        = ~ch_en_reg[gi] | period_zero | at_end;

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
      if (!rsi_rst_n) begin
        period_s_reg <= DEF_P;
        duty_s_reg   <= DEF_D;
        period_a_reg <= DEF_P;
        duty_a_reg   <= DEF_D;
        cnt_reg      <= '0;
        flag_reg     <= 1'b0;
        pend_reg     <= 1'b0;
        pwm_reg      <= 1'b0;
      end else begin
        if (per_hit)  period_s_reg <= lane_merge(period_s_reg, avs_s0_writedata, avs_s0_byteenable);
        if (duty_hit) duty_s_reg   <= lane_merge(duty_s_reg, avs_s0_writedata, avs_s0_byteenable);
        if (load) begin
          period_a_reg <= period_s_reg;
          duty_a_reg   <= duty_s_reg;
        end
        cnt_reg  <= load ? '0 : cnt_reg + ONE;
        pwm_reg  <= ch_en_reg[gi] & ~period_zero & (cnt_reg < duty_a_reg);
        flag_reg <= wrap | (flag_reg & ~clr_vec[gi]);
        // A write landing on the load cycle keeps the channel pending for the next wrap.
        pend_reg <= per_hit | duty_hit | (pend_reg & ~load);
      end
    end

    assign coe_pwm_out[gi]  = pwm_reg;
    assign flag_vec[gi]     = flag_reg;
    assign pend_vec[gi]     = pend_reg;
    assign period_s_arr[gi] = period_s_reg;
    assign duty_s_arr[gi]   = duty_s_reg;
  end

  always_comb begin
    ctrl_word                = '0;
    ctrl_word[NUM_CH-1:0]    = ch_en_reg;
    ctrl_word[16 +: NUM_CH]  = irq_en_reg;
    status_word              = '0;
    status_word[NUM_CH-1:0]  = flag_vec;
    status_word[16 +: NUM_CH] = pend_vec;
  end

  always_comb begin
    rd_word = '0;
    if (avs_s0_address == ADDR_W'(0)) rd_word = ctrl_word;
    if (avs_s0_address == ADDR_W'(1)) rd_word = status_word;
    for (int i = 0; i < NUM_CH; i++) begin
      if (avs_s0_address == ADDR_W'(2 + 2*i)) rd_word = 32'(period_s_arr[i]);
      if (avs_s0_address == ADDR_W'(3 + 2*i)) rd_word = 32'(duty_s_arr[i]);
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
    if (!rsi_rst_n) begin
      readdata_reg <= '0;
    end else if (rd_en) begin
      readdata_reg <= rd_word;
    end
  end

  assign avs_s0_readdata = readdata_reg;
  assign ins_irq         = |(flag_vec & irq_en_reg);

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Self-checking bench for avalon_pwm_multi: directed scenarios plus random bus traffic,
// every cycle compared against a behavioural model of the register map and PWM channels.
module tb_avalon_pwm_multi;

  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 32;
  localparam int          ADDR_W = 4;
  localparam int unsigned DEF_P  = 10;
  localparam int unsigned DEF_D  = 5;
  localparam logic [31:0] CMASK  = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'h1 << CNT_W) - 32'h1);

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              cs    = 1'b0;
  logic              rd    = 1'b0;
  logic              wr    = 1'b0;
  logic [ADDR_W-1:0] addr  = '0;
  logic [3:0]        be    = '0;
  logic [31:0]       wd    = '0;
  logic [31:0]       rdata;
  logic              irq;
  logic [NUM_CH-1:0] pwm;

  always #5 clk = ~clk;

  avalon_pwm_multi #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .ADDR_W    (ADDR_W),
    .DEF_PERIOD(DEF_P),
    .DEF_DUTY  (DEF_D)
  ) dut (
    .csi_clk           (clk),
    .rsi_rst_n         (rst_n),
    .avs_s0_chip_select(cs),
    .avs_s0_read       (rd),
    .avs_s0_write      (wr),
    .avs_s0_address    (addr),
    .avs_s0_byteenable (be),
    .avs_s0_writedata  (wd),
    .avs_s0_readdata   (rdata),
    .ins_irq           (irq),
    .coe_pwm_out       (pwm)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0]       m_ps  [NUM_CH];
  logic [31:0]       m_ds  [NUM_CH];
  logic [31:0]       m_pa  [NUM_CH];
  logic [31:0]       m_da  [NUM_CH];
  logic [31:0]       m_cnt [NUM_CH];
  logic [NUM_CH-1:0] m_en, m_ien, m_flag, m_pend, m_pwm;
  logic [31:0]       m_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_ps[c] = DEF_P; m_ds[c] = DEF_D; m_pa[c] = DEF_P; m_da[c] = DEF_D; m_cnt[c] = 0;
    end
    m_en = '1; m_ien = '0; m_flag = '0; m_pend = '0; m_pwm = '0; m_rd = '0;
  endtask

  function automatic logic [31:0] m_word(input int a);
    logic [31:0] w;
    w = '0;
    if (a == 0) begin
      w[NUM_CH-1:0] = m_en; w[16 +: NUM_CH] = m_ien;
    end else if (a == 1) begin
      w[NUM_CH-1:0] = m_flag; w[16 +: NUM_CH] = m_pend;
    end else if (a < 2 + 2*NUM_CH) begin
      w = ((a % 2) == 0) ? m_ps[(a-2)/2] : m_ds[(a-2)/2];
    end
    return w;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] lanes);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) if (lanes[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // One clock of the reference: period position, output, wrap flag, then bus effects.
  task automatic model_step();
    logic [NUM_CH-1:0] clr;
    logic [31:0]       merged;
    int                a, wc;
    bit                run, last;
    if (!rst_n) begin
      model_reset();
      return;
    end
    a   = int'(addr);
    clr = '0;
    if (cs && rd) m_rd = m_word(a);
    if (cs && wr && a == 1 && be[0]) clr = wd[NUM_CH-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      run  = m_en[c] && (m_pa[c] != 0);
      last = run && (m_cnt[c] == m_pa[c] - 1);
      m_pwm[c]  = run && (m_cnt[c] < m_da[c]);
      m_flag[c] = last || (m_flag[c] && !clr[c]);
      if (!run || last) begin
        m_cnt[c]  = 0;
        m_pa[c]   = m_ps[c];
        m_da[c]   = m_ds[c];
        m_pend[c] = 1'b0;
      end else begin
        m_cnt[c] = m_cnt[c] + 1;
      end
    end
    if (cs && wr) begin
      if (a == 0) begin
        merged = m_merge(m_word(0), wd, be);
        m_en   = merged[NUM_CH-1:0];
        m_ien  = merged[16 +: NUM_CH];
      end else if (a >= 2 && a < 2 + 2*NUM_CH) begin
        wc = (a - 2) / 2;
        if ((a % 2) == 0) m_ps[wc] = m_merge(m_ps[wc], wd, be) & CMASK;
        else              m_ds[wc] = m_merge(m_ds[wc], wd, be) & CMASK;
        m_pend[wc] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("pwm", 32'(pwm), 32'(m_pwm));
    chk("irq", 32'(irq), 32'(|(m_flag & m_ien)));
    chk("rdata", rdata, m_rd);
  endtask

  task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] lanes);
    cs = 1'b1; wr = 1'b1; addr = ADDR_W'(a); wd = d; be = lanes;
    tick();
    cs = 1'b0; wr = 1'b0;
    $display("wr addr=%0d data=0x%08h be=%b pwm=%b irq=%0b", a, d, lanes, pwm, irq);
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; addr = ADDR_W'(a);
    tick();
    cs = 1'b0; rd = 1'b0;
    d = rdata;
    $display("rd addr=%0d data=0x%08h pwm=%b irq=%0b", a, d, pwm, irq);
  endtask

  task automatic wait_cnt(input int c, input int v);
    int k;
    k = 0;
    while (m_cnt[c] != v && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("wait_cnt", m_cnt[c], 32'(v));
  endtask

  task automatic collect(output logic [NUM_CH-1:0][9:0] p);
    p = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      for (int c = 0; c < NUM_CH; c++) p[c] = {p[c][8:0], pwm[c]};
    end
  endtask

  initial begin
    logic [NUM_CH-1:0][9:0] pat;
    logic [31:0]            r, d;
    logic [3:0]             lanes;
    logic                   acc;
    int                     a, op;

    model_reset();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset defaults: 5-high/5-low on every channel starting one cycle after release
    collect(pat);
    for (int c = 0; c < NUM_CH; c++) chk("rst_pattern", 32'(pat[c]), 32'h3E0);
    bus_read(0, r);
    chk("ctrl_rst", r, 32'h0000_000F);
    bus_read(2, r);
    chk("period0_rst", r, 32'd10);

    // Shadow update of DUTY0 mid-period
    wait_cnt(0, 3);
    bus_write(3, 32'd2, 4'hF);
    bus_read(1, r);
    chk("pend0_set", 32'(r[16]), 32'd1);
    wait_cnt(0, 0);
    collect(pat);
    chk("duty2_pattern", 32'(pat[0]), 32'h300);
    bus_read(1, r);
    chk("pend0_clr", 32'(r[16]), 32'd0);
    chk("flags_set", 32'(r[3:0]), 32'hF);

    // Byte lanes on PERIOD1
    bus_write(4, 32'hAABB_CCDD, 4'b0101);
    bus_read(4, r);
    chk("be_lanes", r, 32'h00BB_00DD);
    bus_write(4, 32'h1234_5678, 4'hF);
    bus_read(4, r);
    chk("be_full", r, 32'h1234_5678);
    bus_write(4, 32'd10, 4'hF);
    bus_read(12, r);
    chk("unmapped", r, 32'd0);

    // Channel-2 boundaries
    bus_write(7, 32'd0, 4'hF);
    repeat (12) tick();
    acc = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); acc = acc | pwm[2]; end
    chk("duty_zero", 32'(acc), 32'd0);
    bus_write(7, 32'd12, 4'hF);
    repeat (12) tick();
    acc = 1'b1;
    for (int k = 0; k < 12; k++) begin tick(); acc = acc & pwm[2]; end
    chk("duty_over", 32'(acc), 32'd1);
    bus_write(6, 32'd0, 4'hF);
    repeat (12) tick();
    bus_write(1, 32'h4, 4'h1);
    acc = 1'b0;
    for (int k = 0; k < 15; k++) begin tick(); acc = acc | pwm[2]; end
    chk("period_zero_out", 32'(acc), 32'd0);
    bus_read(1, r);
    chk("period_zero_flag", 32'(r[2]), 32'd0);
    bus_write(6, 32'd10, 4'hF);
    bus_write(7, 32'd5, 4'hF);

    // Interrupt on channel 0 wraps
    bus_write(0, 32'h0001_000F, 4'hF);
    wait_cnt(0, 2);
    bus_write(1, 32'h1, 4'h1);
    chk("irq_cleared", 32'(irq), 32'd0);
    wait_cnt(0, 0);
    chk("irq_wrap", 32'(irq), 32'd1);
    wait_cnt(0, 4);
    bus_write(1, 32'h1, 4'h1);
    chk("irq_w1c", 32'(irq), 32'd0);
    wait_cnt(0, 9);
    bus_write(1, 32'h1, 4'h1);
    chk("irq_w1c_race", 32'(irq), 32'd1);

    // Disable / re-enable channel 3
    bus_write(0, 32'h0001_0007, 4'hF);
    bus_write(9, 32'd3, 4'hF);
    chk("dis_pwm3", 32'(pwm[3]), 32'd0);
    tick();
    bus_read(1, r);
    chk("dis_pend3", 32'(r[19]), 32'd0);
    bus_write(0, 32'h0001_000F, 4'hF);
    collect(pat);
    chk("reen_pattern", 32'(pat[3]), 32'h380);

    // Random bus traffic
    for (int t = 0; t < 500; t++) begin
      a  = int'($urandom_range(0, 15));
      op = int'($urandom_range(0, 9));
      if (op < 4) begin
        bus_read(a, r);
      end else if (op < 8) begin
        d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 14));
        if (a == 0) begin
          d = $urandom;
          if ($urandom_range(0, 2) != 0) d[3:0] = 4'hF;
        end
        if (a == 1) d = $urandom;
        lanes = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        bus_write(a, d, lanes);
      end else begin
        repeat ($urandom_range(1, 8)) tick();
      end
    end

    // Asynchronous reset mid-period
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(pwm), 32'd0);
    chk("async_rst_irq", 32'(irq), 32'd0);
    chk("async_rst_rdata", rdata, 32'd0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    collect(pat);
    for (int c = 0; c < NUM_CH; c++) chk("rerst_pattern", 32'(pat[c]), 32'h3E0);
    bus_read(2, r);
    chk("rerst_period0", r, 32'd10);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
